// File: rtl/sample_iter_ctrl.sv
// sample_iter_ctrl: raster-walks a snapped bounding box, one sample per cycle.
// Optional perf counters when SAMPLE_ITER_PERF_EN is defined.
module sample_iter_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SIGFIG*VERTS*AXIS-1:0]     tri_R13S,
  input  logic [SIGFIG*COLORS-1:0]         color_R13U,
  input  logic [SIGFIG*4-1:0]              box_R13S,
  input  logic                             validTri_R13H,
  input  logic [3:0]                       subSample_RnnnnU,
  input  logic                             halt_in_RnnnnH,
  output logic                             halt_RnnnnH,
  output logic [SIGFIG*VERTS*AXIS-1:0]     tri_R14S,
  output logic [SIGFIG*COLORS-1:0]         color_R14U,
  output logic [SIGFIG*2-1:0]              sample_R14S,
  output logic                             validSamp_R14H
`ifdef SAMPLE_ITER_PERF_EN
  ,
  output logic [31:0]                      perfTri_RnnnnU,
  output logic [31:0]                      perfSamp_RnnnnU
`endif
);

  localparam int S = SIGFIG;
  localparam int W = SIGFIG + 1;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [S*VERTS*AXIS-1:0] tri_q;
  logic [S*COLORS-1:0]     col_q;
  logic signed [S-1:0]     sx, sy;
  logic signed [S-1:0]     llx_q, urx_q, ury_q;
  logic [S-1:0]            step_q;
  logic [S-1:0]            step_in;

  logic signed [S-1:0] in_llx, in_lly, in_urx, in_ury;
  logic signed [W-1:0] nxt_x, nxt_y, ux, uy;
  logic                x_ov, y_ov;
  logic                at_last, accept, load, empty_in;

  assign in_llx = box_R13S[S-1:0];
  assign in_lly = box_R13S[2*S-1:S];
  assign in_urx = box_R13S[3*S-1:2*S];
  assign in_ury = box_R13S[4*S-1:3*S];

  // Decode subsample mode to a stride; anything not one-hot means 1x.
  always_comb begin
    step_in = S'(1) << RADIX;
    if ($onehot(subSample_RnnnnU)) begin
      unique case (1'b1)
        subSample_RnnnnU[0]: step_in = S'(1) << RADIX;
        subSample_RnnnnU[1]: step_in = S'(1) << (RADIX - 1);
        subSample_RnnnnU[2]: step_in = S'(1) << (RADIX - 2);
        subSample_RnnnnU[3]: step_in = S'(1) << (RADIX - 3);
      endcase
    end
  end

  // Step comparisons carry one extra bit so the box edge never wraps.
  always_comb begin
    nxt_x = {sx[S-1], sx} + $signed({1'b0, step_q});
    nxt_y = {sy[S-1], sy} + $signed({1'b0, step_q});
    ux    = {urx_q[S-1], urx_q};
    uy    = {ury_q[S-1], ury_q};
    x_ov  = nxt_x > ux;
    y_ov  = nxt_y > uy;
  end

  assign empty_in = (in_llx > in_urx) || (in_lly > in_ury);
  assign at_last  = (state == TEST) && x_ov && y_ov;
  assign accept   = validTri_R13H && !halt_in_RnnnnH &&
                    ((state == WAIT) || at_last);
  assign load     = accept && !empty_in;

  assign halt_RnnnnH    = (state == TEST) && !at_last;
  assign validSamp_R14H = (state == TEST);
  assign tri_R14S       = tri_q;
  assign color_R14U     = col_q;
  assign sample_R14S    = {sy, sx};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_nx;
  end

  // Next state: enter TEST on a non-empty load, leave after the last sample.
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT: if (load) state_nx = TEST;
      TEST: begin
        if (!halt_in_RnnnnH && at_last)
          state_nx = load ? TEST : WAIT;
      end
      default: state_nx = WAIT;
    endcase
  end

  // Triangle latch and raster walker; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_q  <= '0;
      col_q  <= '0;
      sx     <= '0;
      sy     <= '0;
      llx_q  <= '0;
      urx_q  <= '0;
      ury_q  <= '0;
      step_q <= '0;
    end else if (load) begin
      tri_q  <= tri_R13S;
      col_q  <= color_R13U;
      sx     <= in_llx;
      sy     <= in_lly;
      llx_q  <= in_llx;
      urx_q  <= in_urx;
      ury_q  <= in_ury;
      step_q <= step_in;
    end else if (state == TEST && !halt_in_RnnnnH && !at_last) begin
      if (!x_ov) begin
        sx <= nxt_x[S-1:0];
      end else begin
        sx <= llx_q;
        sy <= nxt_y[S-1:0];
      end
    end
  end

`ifdef SAMPLE_ITER_PERF_EN
  // Saturating counters of loaded triangles and consumed samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfTri_RnnnnU  <= '0;
      perfSamp_RnnnnU <= '0;
    end else begin
      if (load && perfTri_RnnnnU != 32'hFFFF_FFFF)
        perfTri_RnnnnU <= perfTri_RnnnnU + 32'd1;
      if (validSamp_R14H && !halt_in_RnnnnH &&
          perfSamp_RnnnnU != 32'hFFFF_FFFF)
        perfSamp_RnnnnU <= perfSamp_RnnnnU + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// tb_sample_iter_ctrl: directed checks of the raster sample walker.
// Default build (perf counters absent).
module tb_sample_iter_ctrl;

  logic         clk;
  logic         rst;
  logic [215:0] tri_in;
  logic [71:0]  col_in;
  logic [95:0]  box;
  logic         vtri;
  logic [3:0]   ss;
  logic         hin;
  logic         halt;
  logic [215:0] tri_out;
  logic [71:0]  col_out;
  logic [47:0]  samp;
  logic         vsamp;

  int total = 0;
  int bad   = 0;

  sample_iter_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (col_in),
    .box_R13S         (box),
    .validTri_R13H    (vtri),
    .subSample_RnnnnU (ss),
    .halt_in_RnnnnH   (hin),
    .halt_RnnnnH      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (col_out),
    .sample_R14S      (samp),
    .validSamp_R14H   (vsamp)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int llx, input int lly,
                         input int urx, input int ury);
    box = {ury[23:0], urx[23:0], lly[23:0], llx[23:0]};
  endtask

  task automatic chk_samp(input string tag, input int x, input int y,
                          input logic h);
    logic [23:0] ex;
    logic [23:0] ey;
    ex = x[23:0];
    ey = y[23:0];
    chk({tag, "_x"}, samp[23:0], ex);
    chk({tag, "_y"}, samp[47:24], ey);
    chk({tag, "_v"}, vsamp, 1'b1);
    chk({tag, "_h"}, halt, h);
  endtask

  task automatic run_box(input string tag, input int llx, input int lly,
                         input int urx, input int ury,
                         input logic [3:0] mode, input int step);
    int xs[$];
    int ys[$];
    int n;
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step) begin
        xs.push_back(x);
        ys.push_back(y);
      end
    n = xs.size();
    set_box(llx, lly, urx, ury);
    ss   = mode;
    vtri = 1;
    tick();
    vtri = 0;
    chk({tag, "_tri"}, tri_out, tri_in);
    chk({tag, "_col"}, col_out, col_in);
    for (int i = 0; i < n; i++) begin
      chk_samp(tag, xs[i], ys[i], i != n - 1);
      tick();
    end
    chk({tag, "_end_v"}, vsamp, 1'b0);
    chk({tag, "_end_h"}, halt, 1'b0);
  endtask

  initial begin
    rst    = 1;
    tri_in = {27{8'h5a}};
    col_in = {9{8'hc3}};
    box    = '0;
    vtri   = 0;
    ss     = 4'b0001;
    hin    = 0;
    tick();
    tick();
    chk("rst_v", vsamp, 1'b0);
    chk("rst_h", halt, 1'b0);
    chk("rst_s", samp, 48'd0);
    chk("rst_t", tri_out, 216'd0);
    rst = 0;
    tick();

    // 1x: 3x2 samples, halt high on all but the last
    run_box("t1", 0, 0, 2048, 1024, 4'b0001, 1024);
    // 4x: 5x3 samples
    tri_in = {27{8'h17}};
    run_box("t2", 0, 0, 2048, 1024, 4'b0010, 512);
    run_box("s16", 0, 0, 256, 256, 4'b0100, 256);
    run_box("s64", 128, 0, 256, 128, 4'b1000, 128);
    run_box("noh", 0, 0, 1024, 0, 4'b0011, 1024);
    run_box("neg", -1024, -2048, 0, -1024, 4'b0001, 1024);

    // stall while (1024,0) is presented
    set_box(0, 0, 2048, 1024);
    ss   = 4'b0001;
    vtri = 1;
    tick();
    vtri = 0;
    chk_samp("h0", 0, 0, 1'b1);
    tick();
    chk_samp("h1", 1024, 0, 1'b1);
    hin = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_samp("hold", 1024, 0, 1'b1);
    end
    hin = 0;
    tick();
    chk_samp("h2", 2048, 0, 1'b1);
    tick();
    chk_samp("h3", 0, 1024, 1'b1);
    tick();
    chk_samp("h4", 1024, 1024, 1'b1);
    tick();
    chk_samp("h5", 2048, 1024, 1'b0);
    tick();
    chk("h_end", vsamp, 1'b0);

    // back-to-back: B waits through A's halt, loads on A's last
    set_box(0, 0, 1024, 0);
    ss   = 4'b0001;
    vtri = 1;
    tick();
    chk_samp("bA0", 0, 0, 1'b1);
    set_box(512, 512, 512, 1024);
    ss = 4'b0010;
    tick();
    chk_samp("bA1", 1024, 0, 1'b0);
    tick();
    vtri = 0;
    chk_samp("bB0", 512, 512, 1'b1);
    tick();
    chk_samp("bB1", 512, 1024, 1'b0);
    tick();
    chk("b_end", vsamp, 1'b0);

    // empty box consumed silently
    set_box(4096, 0, 0, 0);
    ss   = 4'b0001;
    vtri = 1;
    tick();
    vtri = 0;
    chk("emp_v", vsamp, 1'b0);
    chk("emp_h", halt, 1'b0);
    tick();
    chk("emp_v2", vsamp, 1'b0);

    // single-sample box
    set_box(512, 512, 512, 512);
    vtri = 1;
    tick();
    vtri = 0;
    chk_samp("one", 512, 512, 1'b0);
    tick();
    chk("one_end", vsamp, 1'b0);

    // reset at the third sample
    set_box(0, 0, 2048, 1024);
    vtri = 1;
    tick();
    vtri = 0;
    chk_samp("r0", 0, 0, 1'b1);
    tick();
    chk_samp("r1", 1024, 0, 1'b1);
    tick();
    chk_samp("r2", 2048, 0, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk("rr_v", vsamp, 1'b0);
    chk("rr_h", halt, 1'b0);
    chk("rr_s", samp, 48'd0);
    chk("rr_t", tri_out, 216'd0);
    chk("rr_c", col_out, 72'd0);
    tick();
    chk("rr_v2", vsamp, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
